// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the IF stage: reset/bubble constants, FSM state encoding
// and the IF/ID register bundle.
package if_fetch_stage_pkg;

  localparam logic [31:0] DefaultResetPc  = 32'h0000_3000;
  localparam logic [31:0] DefaultNopInstr = 32'h0000_0000;

  typedef enum logic {
    StFetch = 1'b0,
    StHeld  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        adel;
  } ifid_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Signal bundle around the IF stage: hazard stall, ID redirect, instruction-memory handshake
// and the IF/ID outputs.
//   master : the fetch stage (drives imem_req/imem_addr and ifid_*)
//   slave  : the surroundings (hazard unit, ID stage, instruction memory)
// IF_ALIGN_CHECK_EN adds ifid_adel (address-error flag alongside the IF/ID entry).
interface if_fetch_stage_if;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef IF_ALIGN_CHECK_EN
  logic        ifid_adel;
`endif

  modport master (
    input  stall, redir_valid, redir_target, imem_valid, imem_rdata,
`ifdef IF_ALIGN_CHECK_EN
    output ifid_adel,
`endif
    output imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );

  modport slave (
    output stall, redir_valid, redir_target, imem_valid, imem_rdata,
`ifdef IF_ALIGN_CHECK_EN
    input  ifid_adel,
`endif
    input  imem_req, imem_addr, ifid_instr, ifid_pc4, ifid_valid
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register (the if_id_reg block of the fetch stage).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture ifid_i
//   bubble_i      : replace the entry with NOP_INSTR, valid=0, adel=0; pc4 is kept
//   ifid_i/ifid_o : register input / contents
// With neither load_i nor bubble_i the register holds.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter logic [31:0] NOP_INSTR = DefaultNopInstr
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  logic  bubble_i,
  input  ifid_t ifid_i,
  output ifid_t ifid_o
);

  ifid_t ifid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ifid_q <= '{instr: NOP_INSTR, pc4: RESET_PC, valid: 1'b0, adel: 1'b0};
    end else if (load_i) begin
      ifid_q <= ifid_i;
    end else if (bubble_i) begin
      ifid_q.instr <= NOP_INSTR;
      ifid_q.valid <= 1'b0;
      ifid_q.adel  <= 1'b0;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select, instruction-memory
// fetch handshake and the IF/ID register. Delay-slot architecture: a redirect never flushes,
// it only replaces the PC that follows the delay slot.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus_io        : if_fetch_stage_if.master (stall, redirect, imem handshake, IF/ID outputs)
// Optional macro IF_ALIGN_CHECK_EN: a misaligned next PC is loaded but not fetched; a NOP
// entry flagged with ifid_adel is delivered and the stage halts until reset. Without it the
// two low bits of the next PC are forced to zero.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DefaultResetPc,
  parameter logic [31:0] NOP_INSTR = DefaultNopInstr
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  if_fetch_stage_if.master bus_io
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_plus4, next_pc_raw, next_pc;
  logic [31:0]  pend_target_q, pend_target_d, hold_instr_q, hold_instr_d;
  logic         pend_valid_q, pend_valid_d, req_q, req_d;
  logic         fetch_ack, advance, ifid_load, ifid_bubble;
  ifid_t        ifid_d, ifid_q;
`ifdef IF_ALIGN_CHECK_EN
  logic         misalign_q, misalign_d, halted_q, halted_d;
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign next_pc_raw = bus_io.redir_valid ? bus_io.redir_target :
                       pend_valid_q       ? pend_target_q       : pc_plus4;
`ifdef IF_ALIGN_CHECK_EN
  assign next_pc = next_pc_raw;
`else
  logic [1:0] unused_next_pc_lo;
  assign next_pc           = {next_pc_raw[31:2], 2'b00};
  assign unused_next_pc_lo = next_pc_raw[1:0];
`endif

  // A response only counts while our request is up; this also drops a response that
  // belongs to a request abandoned by reset.
  assign fetch_ack = req_q & bus_io.imem_valid;

  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    advance      = 1'b0;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    ifid_d       = '{instr: bus_io.imem_rdata, pc4: pc_plus4, valid: 1'b1, adel: 1'b0};
`ifdef IF_ALIGN_CHECK_EN
    misalign_d   = misalign_q;
    halted_d     = halted_q;
`endif
    unique case (state_q)
      StFetch: begin
`ifdef IF_ALIGN_CHECK_EN
        if (halted_q) begin
          if (!bus_io.stall) ifid_bubble = 1'b1;
        end else if (misalign_q) begin
          if (!bus_io.stall) begin
            ifid_load    = 1'b1;
            ifid_d.instr = NOP_INSTR;
            ifid_d.adel  = 1'b1;
            halted_d     = 1'b1;
          end
        end else
`endif
        if (fetch_ack) begin
          if (!bus_io.stall) begin
            ifid_load = 1'b1;
            advance   = 1'b1;
          end else begin
            hold_instr_d = bus_io.imem_rdata;
            state_d      = StHeld;
          end
        end else if (!bus_io.stall) begin
          ifid_bubble = 1'b1;
        end
      end
      StHeld: begin
        if (!bus_io.stall) begin
          ifid_load    = 1'b1;
          ifid_d.instr = hold_instr_q;
          advance      = 1'b1;
          state_d      = StFetch;
        end
      end
    endcase

`ifdef IF_ALIGN_CHECK_EN
    if (advance && (next_pc[1:0] != 2'b00)) misalign_d = 1'b1;
`endif

    pc_d = advance ? next_pc : pc_q;

    // A redirect seen while the PC cannot move is parked until the next advance.
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (advance) begin
      pend_valid_d = 1'b0;
    end else if (bus_io.redir_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = bus_io.redir_target;
    end

    req_d = (state_d == StFetch);
`ifdef IF_ALIGN_CHECK_EN
    if (misalign_d || halted_d) req_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      hold_instr_q  <= NOP_INSTR;
      req_q         <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
      halted_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      hold_instr_q  <= hold_instr_d;
      req_q         <= req_d;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
      halted_q      <= halted_d;
`endif
    end
  end

  if_fetch_stage_if_id_reg #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .ifid_i   (ifid_d),
    .ifid_o   (ifid_q)
  );

  assign bus_io.imem_req   = req_q;
  assign bus_io.imem_addr  = pc_q;
  assign bus_io.ifid_instr = ifid_q.instr;
  assign bus_io.ifid_pc4   = ifid_q.pc4;
  assign bus_io.ifid_valid = ifid_q.valid;
`ifdef IF_ALIGN_CHECK_EN
  assign bus_io.ifid_adel  = ifid_q.adel;
`else
  logic unused_adel;
  assign unused_adel = ifid_q.adel;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed walk through the fetch/stall/redirect/reset scenarios,
// then a randomized run scored against a fetch-sequence reference model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam logic [31:0] ResetPc = 32'h0000_3000;
  localparam logic [31:0] Nop     = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  if_fetch_stage_if bus();

  if_fetch_stage #(
    .RESET_PC  (ResetPc),
    .NOP_INSTR (Nop)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned consumed = 0;
  bit sb_on = 1'b0;

  typedef struct {logic req; logic [31:0] addr;} cyc_exp_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} ifid_exp_t;
  cyc_exp_t  cyc_q[$];
  ifid_exp_t ifid_q[$];

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h2400_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic rv, input logic [31:0] rt, input logic v);
    bus.stall        = st;
    bus.redir_valid  = rv;
    bus.redir_target = rt;
    bus.imem_valid   = v;
    bus.imem_rdata   = v ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;
  endtask

  // Scoreboard monitor: per-cycle request/address, and every IF/ID entry taken by ID
  // (ID consumes the entry at an edge where it is valid and the stage is not stalled).
  always @(negedge clk) begin
    cyc_exp_t  e;
    ifid_exp_t f;
    if (sb_on) begin
      if (cyc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_cycle: no expectation queued at %0t", $time);
      end else begin
        e = cyc_q.pop_front();
        check("sb_imem_req", 32'(bus.imem_req), 32'(e.req));
        if (e.req) check("sb_imem_addr", bus.imem_addr, e.addr);
      end
      if (bus.ifid_valid && !bus.stall) begin
        if (ifid_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_ifid: unexpected entry pc4=%h at %0t", bus.ifid_pc4, $time);
        end else begin
          f = ifid_q.pop_front();
          check("sb_ifid_instr", bus.ifid_instr, f.instr);
          check("sb_ifid_pc4", bus.ifid_pc4, f.pc4);
          consumed++;
        end
      end
    end
  end

  // Reference model state: address currently being fetched, a fetched word waiting for the
  // stall to drop, and a parked redirect target.
  logic        m_held, m_pend, adv;
  logic [31:0] m_addr, m_hold_instr, m_pend_t, nxt;
  logic        p_stall, p_redir, p_valid;
  logic [31:0] p_tgt, p_rdata;
  ifid_exp_t   fe;
  cyc_exp_t    ce;

  initial begin
    drv(1'b0, 1'b0, 32'h0, 1'b0);
    #12;
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_instr", bus.ifid_instr, Nop);
    check("rst_pc4", bus.ifid_pc4, ResetPc);
    check("rst_valid", 32'(bus.ifid_valid), 32'h0);
    check("rst_addr", bus.imem_addr, ResetPc);
    #10 rst_ni = 1'b1;
    #1 check("rel_req_low", 32'(bus.imem_req), 32'h0);

    cyc();  // zero-wait fetches
    check("c1_req", 32'(bus.imem_req), 32'h1);
    check("c1_addr", bus.imem_addr, 32'h3000);
    drv(0, 0, 0, 1);
    cyc();
    check("c2_addr", bus.imem_addr, 32'h3004);
    check("c2_valid", 32'(bus.ifid_valid), 32'h1);
    check("c2_pc4", bus.ifid_pc4, 32'h3004);
    check("c2_instr", bus.ifid_instr, word_of(32'h3000));
    drv(0, 0, 0, 0);  // two wait cycles at 3004
    cyc();
    check("w1_addr", bus.imem_addr, 32'h3004);
    check("w1_valid", 32'(bus.ifid_valid), 32'h0);
    drv(0, 0, 0, 0);
    cyc();
    check("w2_addr", bus.imem_addr, 32'h3004);
    check("w2_valid", 32'(bus.ifid_valid), 32'h0);
    drv(0, 0, 0, 1);
    cyc();
    check("w3_instr", bus.ifid_instr, word_of(32'h3004));
    check("w3_pc4", bus.ifid_pc4, 32'h3008);
    check("w3_addr", bus.imem_addr, 32'h3008);
    drv(1, 0, 0, 1);  // stall with the 3008 response
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("held_req", 32'(bus.imem_req), 32'h0);
      check("held_pc4", bus.ifid_pc4, 32'h3008);
      drv(k < 2, 0, 0, 0);
    end
    cyc();
    check("rls_pc4", bus.ifid_pc4, 32'h300C);
    check("rls_instr", bus.ifid_instr, word_of(32'h3008));
    check("rls_addr", bus.imem_addr, 32'h300C);
    drv(0, 0, 0, 1);
    cyc();
    check("ds_addr", bus.imem_addr, 32'h3010);
    drv(0, 1, 32'h3040, 1);  // redirect on the delay-slot advance
    cyc();
    check("br_addr", bus.imem_addr, 32'h3040);
    check("br_valid", 32'(bus.ifid_valid), 32'h1);
    check("br_pc4", bus.ifid_pc4, 32'h3014);
    drv(0, 0, 0, 1);
    cyc();
    drv(0, 1, 32'h3100, 0);  // redirect while waiting on 3044
    cyc();
    check("pend_addr", bus.imem_addr, 32'h3044);
    drv(0, 0, 0, 0);
    cyc();
    drv(0, 0, 0, 1);
    cyc();
    check("pend_tgt", bus.imem_addr, 32'h3100);
    check("pend_pc4", bus.ifid_pc4, 32'h3048);
    drv(0, 0, 0, 1);
    cyc();
    check("pend_clr", bus.imem_addr, 32'h3104);
    drv(1, 1, 32'h3200, 1);  // stall and redirect together
    cyc();
    check("sr_req", 32'(bus.imem_req), 32'h0);
    drv(0, 0, 0, 0);
    cyc();
    check("sr_addr", bus.imem_addr, 32'h3200);
    check("sr_pc4", bus.ifid_pc4, 32'h3108);
    drv(0, 1, 32'hFFFF_FFFC, 1);
    cyc();
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    drv(0, 0, 0, 1);
    cyc();
    check("wrap_pc4", bus.ifid_pc4, 32'h0);
    check("wrap_next", bus.imem_addr, 32'h0);
    drv(0, 1, 32'h3020, 1);
    cyc();
    check("pre_rst_addr", bus.imem_addr, 32'h3020);
    drv(0, 0, 0, 0);
    #2 rst_ni = 1'b0;  // asynchronous reset mid-wait
    #1;
    check("mid_rst_req", 32'(bus.imem_req), 32'h0);
    check("mid_rst_valid", 32'(bus.ifid_valid), 32'h0);
    check("mid_rst_pc4", bus.ifid_pc4, ResetPc);
    check("mid_rst_addr", bus.imem_addr, ResetPc);
    drv(0, 0, 0, 1);  // stale response must be ignored
    @(negedge clk);
    rst_ni = 1'b1;
    #1 check("rel2_req", 32'(bus.imem_req), 32'h0);
    cyc();
    check("rel2_addr", bus.imem_addr, ResetPc);
    check("rel2_valid", 32'(bus.ifid_valid), 32'h0);
    drv(0, 0, 0, 0);

    // Randomized phase
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    m_held = 0; m_pend = 0; m_addr = ResetPc; m_hold_instr = '0; m_pend_t = '0;
    p_stall = 0; p_redir = 0; p_valid = 0; p_tgt = '0; p_rdata = '0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      adv = !p_stall && (m_held || p_valid);
      if (adv) begin
        fe.instr = m_held ? m_hold_instr : p_rdata;
        fe.pc4   = m_addr + 32'd4;
        ifid_q.push_back(fe);
        nxt    = p_redir ? p_tgt : (m_pend ? m_pend_t : m_addr + 32'd4);
        m_addr = {nxt[31:2], 2'b00};
        m_pend = 0;
        m_held = 0;
      end else begin
        if (p_valid) begin
          m_held       = 1;
          m_hold_instr = p_rdata;
        end
        if (p_redir) begin
          m_pend   = 1;
          m_pend_t = p_tgt;
        end
      end
      if (i == 0) sb_on = 1'b1;
      ce.req  = !m_held;
      ce.addr = m_addr;
      cyc_q.push_back(ce);

      p_stall = ($urandom_range(0, 3) == 0);
      p_redir = ($urandom_range(0, 7) == 0);
      p_tgt   = 32'h3000 + 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) p_tgt = 32'hFFFF_FFF8;
`ifdef IF_ALIGN_CHECK_EN
      p_tgt = {p_tgt[31:2], 2'b00};
`endif
      p_valid = bus.imem_req && ($urandom_range(0, 2) != 0);
      p_rdata = p_valid ? word_of(bus.imem_addr) : $urandom;
      bus.stall        = p_stall;
      bus.redir_valid  = p_redir;
      bus.redir_target = p_tgt;
      bus.imem_valid   = p_valid;
      bus.imem_rdata   = p_rdata;
    end
    @(negedge clk);
    #1 sb_on = 1'b0;
    check("sb_drained", 32'(cyc_q.size()), 32'h0);
    check("sb_backlog", 32'(ifid_q.size() <= 1), 32'h1);
    check("sb_progress", 32'(consumed > 500), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
